// File: rtl/uart_program_loader_if.sv
// Program-load bus: serial line in, instruction-memory write port and BIP control out.
interface uart_program_loader_if #(
  parameter int ADDR_W = 8
);
  logic              i_rx;
  logic              o_prog_we;
  logic [ADDR_W-1:0] o_prog_addr;
  logic [15:0]       o_prog_data;
  logic              o_bip_rst;
  logic              o_load_done;
  logic              o_frame_err;

  // Loader side drives the memory port and BIP control, samples the line.
  modport master (
    input  i_rx,
    output o_prog_we, o_prog_addr, o_prog_data, o_bip_rst, o_load_done, o_frame_err
  );

  // Host/memory side drives the line and consumes the write port.
  modport slave (
    output i_rx,
    input  o_prog_we, o_prog_addr, o_prog_data, o_bip_rst, o_load_done, o_frame_err
  );
endinterface

// File: rtl/uart_program_loader.sv
// UART (8N1, 16x oversampled) receiver feeding a framed program loader:
// SYNC_BYTE, word count N, then N big-endian 16-bit words written to
// instruction memory from address 0. BIP is held in reset until a full
// program has been written.
module uart_program_loader #(
  parameter int         CLK_FREQ  = 50_000_000,
  parameter int         BAUD_RATE = 9600,
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_program_loader_if.master bus
);

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  typedef enum logic [2:0] {
    LD_WAIT_SYNC,
    LD_GET_CNT,
    LD_GET_HI,
    LD_GET_LO,
    LD_DONE
  } ld_state_t;

  // Receiver signals
  logic             rx_s1, rx_s2, rx_q;
  logic             fall;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       rx_shift;
  rx_state_t        rx_state, rx_next;
  logic             start_det, tick_clr, bit_shift, rx_ok, rx_bad;
  logic             byte_vld, frame_err_r;

  // Loader signals
  ld_state_t         ld_state, ld_next;
  logic              wr, sync_hit, frame_abort;
  logic [7:0]        idx, cnt, hi_byte;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [15:0]       prog_data;
  logic              bip_rst, load_done;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      rx_s1 <= bus.i_rx;
      rx_s2 <= rx_s1;
      rx_q  <= rx_s2;
    end
  end

  assign fall = rx_q & ~rx_s2;
  assign tick = (div_cnt == DIV_LAST);

  // Oversampling divider, realigned on every detected start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      div_cnt <= '0;
    else if (start_det || tick)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  // Receiver state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  // Receiver next-state and sampling strobes.
  always_comb begin
    rx_next   = rx_state;
    start_det = 1'b0;
    tick_clr  = 1'b0;
    bit_shift = 1'b0;
    rx_ok     = 1'b0;
    rx_bad    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (fall) begin
          start_det = 1'b1;
          tick_clr  = 1'b1;
          rx_next   = RX_START;
        end
      end
      RX_START: begin
        // Mid-start re-check rejects short low glitches on the idle line.
        if (tick && tick_cnt == 4'd7) begin
          tick_clr = 1'b1;
          rx_next  = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (tick && tick_cnt == 4'd15) begin
          bit_shift = 1'b1;
          if (bit_cnt == 3'd7) rx_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (tick && tick_cnt == 4'd15) begin
          if (rx_s2) begin
            rx_ok   = 1'b1;
            rx_next = RX_IDLE;
          end else begin
            rx_bad  = 1'b1;
            rx_next = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        // A held-low line must return high before another start is accepted.
        if (rx_s2) rx_next = RX_IDLE;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // Tick and bit counters; tick_cnt wraps naturally every 16 ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (tick_clr)
        tick_cnt <= '0;
      else if (tick)
        tick_cnt <= tick_cnt + 1'b1;
      if (tick_clr)
        bit_cnt <= '0;
      else if (bit_shift)
        bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // LSB-first data shift register.
  always_ff @(posedge clk) begin
    if (bit_shift) rx_shift <= {rx_s2, rx_shift[7:1]};
  end

  // Byte-complete and framing-error pulses, one clock after the stop sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_vld    <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      byte_vld    <= rx_ok;
      frame_err_r <= rx_bad;
    end
  end

  assign sync_hit    = byte_vld && (rx_shift == SYNC_BYTE) &&
                       (ld_state == LD_WAIT_SYNC || ld_state == LD_DONE);
  assign frame_abort = frame_err_r && (ld_state != LD_DONE);

  // Loader state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ld_state <= LD_WAIT_SYNC;
    else     ld_state <= ld_next;
  end

  // Loader next-state and write request.
  always_comb begin
    ld_next = ld_state;
    wr      = 1'b0;
    if (byte_vld) begin
      case (ld_state)
        LD_WAIT_SYNC, LD_DONE: begin
          if (rx_shift == SYNC_BYTE) ld_next = LD_GET_CNT;
        end
        LD_GET_CNT: ld_next = (rx_shift == 8'd0) ? LD_WAIT_SYNC : LD_GET_HI;
        LD_GET_HI:  ld_next = LD_GET_LO;
        LD_GET_LO: begin
          wr      = 1'b1;
          ld_next = ((idx + 8'd1) == cnt) ? LD_DONE : LD_GET_HI;
        end
        default: ld_next = LD_WAIT_SYNC;
      endcase
    end else if (frame_abort) begin
      ld_next = LD_WAIT_SYNC;
    end
  end

  // Frame header capture: word count and pending high byte.
  always_ff @(posedge clk) begin
    if (byte_vld && ld_state == LD_GET_CNT) cnt     <= rx_shift;
    if (byte_vld && ld_state == LD_GET_HI)  hi_byte <= rx_shift;
  end

  // Memory write port, word index and BIP release/hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prog_we   <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      bip_rst   <= 1'b1;
      load_done <= 1'b0;
      idx       <= '0;
    end else begin
      prog_we <= wr;
      if (wr) begin
        prog_addr <= ADDR_W'(idx);
        prog_data <= {hi_byte, rx_shift};
        idx       <= idx + 8'd1;
      end
      if (sync_hit) begin
        idx       <= '0;
        bip_rst   <= 1'b1;
        load_done <= 1'b0;
      end else if (ld_state == LD_DONE) begin
        // Reached one clock after the last write strobe.
        bip_rst   <= 1'b0;
        load_done <= 1'b1;
      end
      if (frame_abort) idx <= '0;
    end
  end

  assign bus.o_prog_we   = prog_we;
  assign bus.o_prog_addr = prog_addr;
  assign bus.o_prog_data = prog_data;
  assign bus.o_bip_rst   = bip_rst;
  assign bus.o_load_done = load_done;
  assign bus.o_frame_err = frame_err_r;

endmodule
